// File: rtl/systolic_acc_drain_pkg.sv
// systolic_acc_drain_pkg: shared FSM encoding, default widths and sign-extension helper
package systolic_acc_drain_pkg;

    typedef logic [0:0] state_t;

    localparam state_t IDLE = 1'b0;
    localparam state_t DRAIN = 1'b1;

    localparam int ACC_W_DEF = 40;
    localparam int OUT_W_DEF = 32;

    // Sign-extends the low w bits of v to 64 bits; callers truncate to the accumulator width.
    function automatic logic [63:0] sext_to_acc(input logic [63:0] v, input int w);
        return 64'($signed(v << (64 - w)) >>> (64 - w));
    endfunction

endpackage

// File: rtl/systolic_acc_drain_sat_narrow.sv
// systolic_acc_drain_sat_narrow: combinational signed narrowing, saturating or truncating
module systolic_acc_drain_sat_narrow #(
    parameter int IN_W = 40,
    parameter int OUT_W = 32,
    parameter bit SAT_EN = 1'b1
) (
    input  logic [IN_W-1:0]  v_i,
    output logic [OUT_W-1:0] q_o,
    output logic             clip_o
);

    logic [IN_W-OUT_W:0] hi;
    logic ovf;

    // Value fits iff every bit from OUT_W-1 upward equals the sign bit.
    assign hi = v_i[IN_W-1:OUT_W-1];
    assign ovf = !(&hi || ~|hi);
    assign clip_o = SAT_EN && ovf;
    assign q_o = !clip_o ? v_i[OUT_W-1:0] :
                 v_i[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};

endmodule

// File: rtl/systolic_acc_drain.sv
// systolic_acc_drain: column accumulators with ping-pong shadow bank drained one column per beat
module systolic_acc_drain
    import systolic_acc_drain_pkg::*;
#(
    parameter int ARR_SIZE = 4,
    parameter int IN_W = 32,
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int ADDR_W = 4,
    parameter bit SAT_EN = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     mac_valid_i,
    input  logic [ARR_SIZE*IN_W-1:0] mac_data_i,
    input  logic                     acc_clear_i,
    input  logic                     drain_req_i,
    input  logic [ADDR_W-1:0]        drain_base_addr_i,
    output logic                     busy_o,
    output logic                     ob_valid_o,
    input  logic                     ob_ready_i,
    output logic [ADDR_W-1:0]        ob_addr_o,
    output logic [OUT_W-1:0]         ob_data_o,
    output logic                     sat_flag_o
);

    localparam int IDX_W = $clog2(ARR_SIZE);

    state_t state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic sat_q, sat_d;
    logic start, beat, last, clip;
    logic [OUT_W-1:0] narrowed;
    logic [ACC_W-1:0] shad [ARR_SIZE];

    assign start = (state_q == IDLE) && drain_req_i;
    assign beat = ob_valid_o && ob_ready_i;
    assign last = idx_q == IDX_W'(ARR_SIZE - 1);

    for (genvar c = 0; c < ARR_SIZE; c++) begin : g_col
        logic [ACC_W-1:0] live_q, live_d, shad_q, shad_d, add, sum;
        assign add = mac_valid_i ? ACC_W'(sext_to_acc(64'(mac_data_i[c*IN_W +: IN_W]), IN_W)) : '0;
        assign sum = (acc_clear_i ? '0 : live_q) + add;
        // The drain cycle's add goes to the snapshot only, so live restarts from zero.
        assign live_d = start ? '0 : sum;
        assign shad_d = start ? sum : shad_q;
        assign shad[c] = shad_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                live_q <= '0;
                shad_q <= '0;
            end else begin
                live_q <= live_d;
                shad_q <= shad_d;
            end
        end
    end

    systolic_acc_drain_sat_narrow #(
        .IN_W(ACC_W),
        .OUT_W(OUT_W),
        .SAT_EN(SAT_EN)
    ) u_narrow (
        .v_i(shad[idx_q]),
        .q_o(narrowed),
        .clip_o(clip)
    );

    always_comb begin
        state_d = start ? DRAIN : (beat && last) ? IDLE : state_q;
        idx_d = start ? '0 : beat ? idx_q + 1'b1 : idx_q;
        base_d = start ? drain_base_addr_i : base_q;
        sat_d = (beat && clip) ? 1'b1 : acc_clear_i ? 1'b0 : sat_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q <= '0;
            base_q <= '0;
            sat_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            base_q <= base_d;
            sat_q <= sat_d;
        end
    end

    assign busy_o = state_q == DRAIN;
    assign ob_valid_o = busy_o;
    assign ob_addr_o = busy_o ? base_q + ADDR_W'(idx_q) : '0;
    assign ob_data_o = busy_o ? narrowed : '0;
    assign sat_flag_o = sat_q;

endmodule

// File: tb/tb_systolic_acc_drain.sv
// tb_systolic_acc_drain: directed checks of accumulate, drain, wrap, backpressure, saturation, reset
module tb_systolic_acc_drain;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mac_valid = 1'b0;
    logic acc_clear = 1'b0;
    logic drain_req = 1'b0;
    logic ob_ready = 1'b1;
    logic [127:0] mac_data = '0;
    logic [3:0] base_addr = '0;
    logic busy, ob_valid, sat_flag, busy_t, ob_valid_t, sat_flag_t;
    logic [3:0] ob_addr, ob_addr_t;
    logic [31:0] ob_data, ob_data_t;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    systolic_acc_drain #(.SAT_EN(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .mac_valid_i(mac_valid), .mac_data_i(mac_data),
        .acc_clear_i(acc_clear), .drain_req_i(drain_req), .drain_base_addr_i(base_addr),
        .busy_o(busy), .ob_valid_o(ob_valid), .ob_ready_i(ob_ready), .ob_addr_o(ob_addr),
        .ob_data_o(ob_data), .sat_flag_o(sat_flag)
    );

    systolic_acc_drain #(.SAT_EN(1'b0)) dut_t (
        .clk_i(clk), .rst_ni(rst_n), .mac_valid_i(mac_valid), .mac_data_i(mac_data),
        .acc_clear_i(acc_clear), .drain_req_i(drain_req), .drain_base_addr_i(base_addr),
        .busy_o(busy_t), .ob_valid_o(ob_valid_t), .ob_ready_i(ob_ready), .ob_addr_o(ob_addr_t),
        .ob_data_o(ob_data_t), .sat_flag_o(sat_flag_t)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic accum(input logic [31:0] a, b, c, d, input int n);
        mac_valid = 1'b1;
        mac_data = {d, c, b, a};
        repeat (n) tick();
        mac_valid = 1'b0;
    endtask

    task automatic start_drain(input logic [3:0] base);
        drain_req = 1'b1;
        base_addr = base;
        tick();
        drain_req = 1'b0;
    endtask

    task automatic expect_beats(input logic [3:0] base, input int first,
                                input logic [31:0] e0, e1, e2, e3);
        logic [31:0] e [4];
        logic [3:0] a;
        e = '{e0, e1, e2, e3};
        for (int i = first; i < 4; i++) begin
            a = base + 4'(i);
            chk("beat_valid", 64'(ob_valid), 64'd1);
            chk("beat_busy", 64'(busy), 64'd1);
            chk("beat_addr", 64'(ob_addr), 64'(a));
            chk("beat_data", 64'(ob_data), 64'(e[i]));
            tick();
        end
        chk("end_valid", 64'(ob_valid), 64'd0);
        chk("end_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(ob_valid), 64'd0);
        chk("rst_addr", 64'(ob_addr), 64'd0);
        chk("rst_data", 64'(ob_data), 64'd0);
        chk("rst_sat", 64'(sat_flag), 64'd0);
        chk("rst_valid_t", 64'(ob_valid_t), 64'd0);
        rst_n = 1'b1;
        tick();

        accum(32'd10, 32'd20, 32'd30, 32'd40, 3);
        start_drain(4'd2);
        expect_beats(4'd2, 0, 32'd30, 32'd60, 32'd90, 32'd120);

        accum(32'd1, 32'd2, 32'd3, 32'd4, 1);
        start_drain(4'd14);
        expect_beats(4'd14, 0, 32'd1, 32'd2, 32'd3, 32'd4);

        accum(32'd100, 32'd200, 32'd300, 32'd400, 1);
        start_drain(4'd0);
        chk("bp_addr0", 64'(ob_addr), 64'd0);
        chk("bp_data0", 64'(ob_data), 64'd100);
        tick();
        ob_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_valid", 64'(ob_valid), 64'd1);
            chk("bp_hold_addr", 64'(ob_addr), 64'd1);
            chk("bp_hold_data", 64'(ob_data), 64'd200);
        end
        ob_ready = 1'b1;
        expect_beats(4'd0, 1, 32'd100, 32'd200, 32'd300, 32'd400);

        accum(32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'd0, 2);
        start_drain(4'd0);
        chk("sat_pre_flag", 64'(sat_flag), 64'd0);
        chk("sat_data0", 64'(ob_data), 64'h7FFF_FFFF);
        chk("trunc_data0", 64'(ob_data_t), 64'hFFFF_FFFE);
        tick();
        chk("sat_flag_set", 64'(sat_flag), 64'd1);
        chk("sat_data1", 64'(ob_data), 64'h8000_0000);
        chk("trunc_data1", 64'(ob_data_t), 64'h0000_0000);
        chk("trunc_flag", 64'(sat_flag_t), 64'd0);
        repeat (3) tick();
        chk("sat_done_valid", 64'(ob_valid), 64'd0);
        chk("sat_flag_hold", 64'(sat_flag), 64'd1);
        acc_clear = 1'b1;
        tick();
        acc_clear = 1'b0;
        chk("sat_flag_clr", 64'(sat_flag), 64'd0);

        mac_valid = 1'b1;
        mac_data = {4{32'd5}};
        start_drain(4'd0);
        mac_data = {4{32'd7}};
        drain_req = 1'b1;
        base_addr = 4'd9;
        chk("conc_addr0", 64'(ob_addr), 64'd0);
        chk("conc_data0", 64'(ob_data), 64'd5);
        tick();
        mac_valid = 1'b0;
        drain_req = 1'b0;
        expect_beats(4'd0, 1, 32'd5, 32'd5, 32'd5, 32'd5);
        start_drain(4'd3);
        expect_beats(4'd3, 0, 32'd7, 32'd7, 32'd7, 32'd7);

        accum(32'd1, 32'd2, 32'd3, 32'd4, 1);
        start_drain(4'd0);
        tick();
        tick();
        chk("mid_addr2", 64'(ob_addr), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(ob_valid), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_addr", 64'(ob_addr), 64'd0);
        chk("arst_data", 64'(ob_data), 64'd0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_valid", 64'(ob_valid), 64'd0);
        end
        accum(32'd1, 32'd1, 32'd1, 32'd1, 1);
        start_drain(4'd5);
        expect_beats(4'd5, 0, 32'd1, 32'd1, 32'd1, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
